// File: rtl/tile_text_renderer.sv
// Tile text renderer: 80x60 grid of 8x8 glyphs, 16-entry RGB332 palette, blinking block cursor.
// Three pix_en-qualified stages: tile-map lookup, glyph lookup, colour resolve.
module tile_text_renderer #(
    parameter int unsigned BLINK_LOG2 = 5,
    parameter int unsigned MAP_COLS   = 80
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        pix_en,
    input  logic [9:0]  hcount,
    input  logic [9:0]  vcount,
    input  logic        bright,
    input  logic        hsync_in,
    input  logic        vsync_in,
    output logic [12:0] map_addr,
    input  logic [15:0] map_data,
    output logic [10:0] glyph_addr,
    input  logic [7:0]  glyph_data,
    input  logic        pal_we,
    input  logic [3:0]  pal_addr,
    input  logic [7:0]  pal_wdata,
    input  logic        cursor_en,
    input  logic [6:0]  cursor_x,
    input  logic [5:0]  cursor_y,
    output logic [7:0]  rgb,
    output logic        hsync,
    output logic        vsync,
    output logic        bright_out
);

    function automatic logic [7:0] pal_default(input logic [3:0] i);
        return {i[2], i[2], i[3], i[1], i[1], i[3], i[0], i[3]};
    endfunction

    logic [7:0]  palette [16];
    logic [BLINK_LOG2:0] frame_cnt;

    // stage 0
    logic [6:0]  col_s0;
    logic [5:0]  row_s0;
    logic [2:0]  px_s0;
    logic [2:0]  py_s0;
    logic        hs_s0, vs_s0, br_s0;

    // stage 1
    logic [6:0]  col_s1;
    logic [5:0]  row_s1;
    logic [2:0]  px_s1;
    logic [7:0]  attr_s1;
    logic        hs_s1, vs_s1, br_s1;

    logic [6:0]  col_in;
    logic [5:0]  row_in;
    logic [12:0] map_addr_next;
    logic        glyph_bit;
    logic        cursor_hit;
    logic [3:0]  pal_idx;
    logic [7:0]  rgb_next;
    logic        unused_vcount_msb;

    assign col_in            = hcount[9:3];
    assign row_in            = vcount[8:3];
    assign unused_vcount_msb = vcount[9];

    // constant multiply by MAP_COLS reduces to the (row<<6)+(row<<4) shift-add for 80 columns
    always_comb begin
        map_addr_next = '0;
        if (bright) begin
            map_addr_next = 13'(row_in) * 13'(MAP_COLS) + 13'(col_in);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            col_s0   <= '0;
            row_s0   <= '0;
            px_s0    <= '0;
            py_s0    <= '0;
            hs_s0    <= 1'b1;
            vs_s0    <= 1'b1;
            br_s0    <= 1'b0;
            map_addr <= '0;
        end else if (pix_en) begin
            col_s0   <= col_in;
            row_s0   <= row_in;
            px_s0    <= hcount[2:0];
            py_s0    <= vcount[2:0];
            hs_s0    <= hsync_in;
            vs_s0    <= vsync_in;
            br_s0    <= bright;
            map_addr <= map_addr_next;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            col_s1     <= '0;
            row_s1     <= '0;
            px_s1      <= '0;
            attr_s1    <= '0;
            hs_s1      <= 1'b1;
            vs_s1      <= 1'b1;
            br_s1      <= 1'b0;
            glyph_addr <= '0;
        end else if (pix_en) begin
            col_s1     <= col_s0;
            row_s1     <= row_s0;
            px_s1      <= px_s0;
            attr_s1    <= map_data[15:8];
            hs_s1      <= hs_s0;
            vs_s1      <= vs_s0;
            br_s1      <= br_s0;
            glyph_addr <= {map_data[7:0], py_s0};
        end
    end

    // cursor swaps fg/bg, which is the same as inverting the glyph bit
    always_comb begin
        glyph_bit  = glyph_data[3'd7 - px_s1];
        cursor_hit = cursor_en && (col_s1 == cursor_x) && (row_s1 == cursor_y)
                     && frame_cnt[BLINK_LOG2];
        pal_idx    = (glyph_bit ^ cursor_hit) ? attr_s1[3:0] : attr_s1[7:4];
        rgb_next   = br_s1 ? palette[pal_idx] : 8'h00;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rgb        <= '0;
            hsync      <= 1'b1;
            vsync      <= 1'b1;
            bright_out <= 1'b0;
        end else if (pix_en) begin
            rgb        <= rgb_next;
            hsync      <= hs_s1;
            vsync      <= vs_s1;
            bright_out <= br_s1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            frame_cnt <= '0;
        end else if (pix_en && vs_s0 && !vsync_in) begin
            frame_cnt <= frame_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int unsigned i = 0; i < 16; i++) begin
                palette[i] <= pal_default(4'(i));
            end
        end else if (pal_we) begin
            palette[pal_addr] <= pal_wdata;
        end
    end

endmodule
